// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM state encodings,
// default parameter values and the len-field width helper.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_ISSUE = 2'd1,
    RDR_DRAIN = 2'd2,
    RDR_DONE  = 2'd3
  } rdr_state_t;

  localparam int RDR_DEF_AW        = 16;
  localparam int RDR_DEF_DW        = 8;
  localparam int RDR_DEF_MAX_WORDS = 8;
  localparam int RDR_DEF_RD_LAT    = 1;

  // len carries word count minus one, so it needs clog2(MAX_WORDS) bits, never fewer than one.
  function automatic int rdr_len_width(input int max_words);
    return (max_words > 2) ? $clog2(max_words) : 1;
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request/RAM/result bundle of the burst reader. The sext signal exists only
// when RDR_SIGNEXT_EN is defined.
interface ram_burst_reader_if
  import ram_burst_reader_pkg::*;
#(
  parameter int AW        = RDR_DEF_AW,
  parameter int DW        = RDR_DEF_DW,
  parameter int MAX_WORDS = RDR_DEF_MAX_WORDS
) ();
  localparam int LW = rdr_len_width(MAX_WORDS);

  // Handshake: start is taken on a rising edge only while busy=0 (which includes
  // the done cycle); base_addr/len/sext are sampled at that same edge only. busy
  // stays high until the last word lands, and done pulses for one cycle with q final.
  logic                    start;
  logic [AW-1:0]           base_addr;
  logic [LW-1:0]           len;
`ifdef RDR_SIGNEXT_EN
  logic                    sext;
`endif
  logic                    mem_re;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_rdata;
  logic                    busy;
  logic                    done;
  logic [MAX_WORDS*DW-1:0] q;

  modport slave (
    input  start, base_addr, len,
`ifdef RDR_SIGNEXT_EN
    input  sext,
`endif
    input  mem_rdata,
    output mem_re, mem_addr, busy, done, q
  );

  modport master (
    output start, base_addr, len,
`ifdef RDR_SIGNEXT_EN
    output sext,
`endif
    output mem_rdata,
    input  mem_re, mem_addr, busy, done, q
  );

endinterface

// File: rtl/ram_burst_reader_lat_pipe.sv
// rdr_lat_pipe: LAT-stage shift register of {valid, word index} that lines up
// each issued read with the edge its RAM data must be captured on.
module rdr_lat_pipe #(
  parameter int LAT = 1,
  parameter int LW  = 3
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [LW-1:0] idx_i,
  output logic          vld_o,
  output logic [LW-1:0] idx_o
);

  logic [LAT-1:0] vld_q;
  logic [LW-1:0]  idx_q [LAT];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) idx_q[s] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign idx_o = idx_q[LAT-1];

endmodule

// File: rtl/ram_burst_reader.sv
// Multi-word RAM burst reader: issues len+1 sequential reads and packs the
// returned words little-endian into q. Optional sign fill under RDR_SIGNEXT_EN.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int AW        = RDR_DEF_AW,
  parameter int DW        = RDR_DEF_DW,
  parameter int MAX_WORDS = RDR_DEF_MAX_WORDS,
  parameter int RD_LAT    = RDR_DEF_RD_LAT
) (
  input  logic               clk,
  input  logic               rst,
  ram_burst_reader_if.slave  bus,
  output rdr_state_t         state_o
);

  localparam int LW = rdr_len_width(MAX_WORDS);
  localparam int QW = MAX_WORDS * DW;

  rdr_state_t    state_q;
  logic          mem_re_q;
  logic [AW-1:0] mem_addr_q;
  logic          busy_q;
  logic          done_q;
  logic [QW-1:0] q_q;
  logic [QW-1:0] q_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] iss_idx_q;
`ifdef RDR_SIGNEXT_EN
  logic          sext_q;
`endif

  logic          cap_vld;
  logic [LW-1:0] cap_idx;
  logic          last_cap;

  // The pipe sees the read that the RAM samples at this edge, tagged with its word index.
  rdr_lat_pipe #(
    .LAT (RD_LAT),
    .LW  (LW)
  ) u_lat_pipe (
    .clk_i (clk),
    .clr_i (rst),
    .vld_i (mem_re_q),
    .idx_i (iss_idx_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  assign last_cap = cap_vld && (cap_idx == len_q);

  always_comb begin
    q_d = q_q;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (cap_vld && (cap_idx == LW'(k))) begin
        q_d[k*DW +: DW] = bus.mem_rdata;
      end
`ifdef RDR_SIGNEXT_EN
      else if (last_cap && sext_q && (LW'(k) > cap_idx)) begin
        q_d[k*DW +: DW] = {DW{bus.mem_rdata[DW-1]}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RDR_IDLE;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      len_q      <= '0;
      iss_idx_q  <= '0;
`ifdef RDR_SIGNEXT_EN
      sext_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      q_q    <= q_d;
      case (state_q)
        RDR_ISSUE: begin
          if (iss_idx_q == len_q) begin
            mem_re_q <= 1'b0;
            state_q  <= RDR_DRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + AW'(1);
            iss_idx_q  <= iss_idx_q + LW'(1);
          end
        end
        RDR_DRAIN: begin
          if (last_cap) begin
            state_q <= RDR_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new burst; the pipe is empty here.
          if (bus.start) begin
            state_q    <= RDR_ISSUE;
            mem_re_q   <= 1'b1;
            mem_addr_q <= bus.base_addr;
            len_q      <= bus.len;
            iss_idx_q  <= '0;
            busy_q     <= 1'b1;
            q_q        <= '0;
`ifdef RDR_SIGNEXT_EN
            sext_q     <= bus.sext;
`endif
          end else begin
            state_q <= RDR_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.mem_re   = mem_re_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign state_o      = state_q;

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Parametrised multi-word RAM read assembler; successor to the fixed 8-byte opcode/operand fetch reader.
- Takes a start request carrying a base address and a word count, issues pipelined sequential reads to a synchronous RAM with configurable read latency, and packs the returned words little-endian into one wide result.
- Sits between the control-state sequencer and the program/data RAM; serves opcode fetch, operand fetch and POP/MOV-style multi-byte loads.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data word width.
- MAX_WORDS, 8, maximum words per burst; result width is MAX_WORDS*DW.
- RD_LAT, 1, RAM read latency in clocks (legal values 1..4).
- LW (derived, not overridable), max(1, clog2(MAX_WORDS)), width of the len field.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  burst request; sampled only while busy=0.
- base_addr  in  AW  address of word 0.
- len  in  LW  word count minus 1 (0 means 1 word, MAX_WORDS-1 means MAX_WORDS words).
- mem_re  out  1  RAM read enable.
- mem_addr  out  AW  RAM read address.
- mem_rdata  in  DW  RAM read data, valid RD_LAT edges after the address is sampled.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse; q is final in that cycle.
- q  out  MAX_WORDS*DW  assembled result. Word k occupies bits [k*DW +: DW].

Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.

Behaviour:
- Reset values: mem_re=0, mem_addr=0, busy=0, done=0, q=0. The FSM goes to IDLE and the latency pipe is cleared.
- Reset asserted mid-burst aborts the burst. In-flight returns are discarded and q is zeroed.
- FSM states:
  - IDLE: start=1 at edge E0 → ISSUE. At E0, latch n=len+1, load the address counter with base_addr, clear q to 0, set busy=1.
  - ISSUE: each cycle mem_re=1 and mem_addr=base+i, for i=0..n-1 over n consecutive cycles with no bubbles. After the last issue → DRAIN.
  - DRAIN: mem_re=0, mem_addr holds its last value. Wait for outstanding returns. When the last word is captured → DONE.
  - DONE: one cycle. done=1, busy=0. Then → IDLE.
- Capture rule:
  - The RAM samples word i's address at edge E(i+1).
  - The block captures mem_rdata into q word i at edge E(i+1+RD_LAT).
  - Capture is tracked by an RD_LAT-deep valid+index shift pipe.
- Latency: start sampled at E0; done is high in the cycle after E(n+RD_LAT).
  - Example: n=8, RD_LAT=1 → done after E9.
- busy is 1 from after E0 through the cycle of the last capture edge. It is 0 in the DONE cycle.
- A start seen during the DONE cycle is accepted, because busy=0 in that cycle; a new burst begins at that edge.
- start while busy=1 is ignored; no queueing.
- Words above n-1 read as 0 (no sign-fill without the optional feature).
- q holds its value after done until the next accepted start.
- Address arithmetic is modulo 2^AW; 0xFFFF+1 wraps to 0x0000 with no flag.
- base_addr and len are sampled only at acceptance. Later changes have no effect on the burst in progress.
- Issuing and capturing overlap: for RD_LAT=1, cycle i+2 both issues word i+1 and captures word i.

Optional Feature:
- Macro: RDR_SIGNEXT_EN.
- Defined: adds input port sext (1 bit), sampled with start.
  - If sext=1, on the last capture every q word above n-1 is filled with the replicated MSB of word n-1.
  - The fill appears in the same cycle done rises.
- Undefined: the sext port is absent and unused words are zero.

Decomposition:
- Shared header alongside the existing state definitions holds:
  - FSM state encodings: RDR_IDLE, RDR_ISSUE, RDR_DRAIN, RDR_DONE.
  - Default parameter values.
- Sub-module rdr_lat_pipe: RD_LAT-stage shift register of {valid, index[LW]}, with synchronous clear. It drives the capture enable and the word select.

Test Plan:
- Reset then idle: after rst, hold start=0 for 10 cycles → mem_re=0, busy=0, done=0, q=0 throughout.
- Full burst: RAM[0x1000+i]=0x10+i, start with base=0x1000, len=7, RD_LAT=1 → mem_addr 0x1000..0x1007 on 8 consecutive cycles; done after E9; q=0x1716151413121110.
- Short burst and zero-fill: q preloaded nonzero, base=0x2000, len=0, RAM[0x2000]=0xA5 → done after E2; q=0x00000000000000A5. Repeat with RD_LAT=3 → done after E4, same q.
- Wrap and back-to-back: base=0xFFFE, len=3 → addresses FFFE, FFFF, 0000, 0001. Assert start again in the DONE cycle → the second burst's first mem_re is in the next cycle, with no idle gap. start pulses while busy → ignored.
- Reset mid-burst: rst at cycle 4 of an 8-word burst → next cycle mem_re=0, busy=0, q=0, and no done pulse. A new start afterward completes correctly.
- RDR_SIGNEXT_EN: len=1, sext=1, RAM data {0x34, 0x92} → q=0xFFFFFFFFFFFF9234. With sext=0 → q=0x0000000000009234.
